mips_multicycle_sequencer: RTL and testbench

//  Multi-cycle control FSM for the non-pipelined MIPS core. Drives the word-indexed PC into the

---
 rtl/mips_ctrl_pkg.sv | 34 +++
 rtl/mips_instr_class.sv | 38 +++
 rtl/mips_multicycle_sequencer.sv | 128 ++++++++++++
 tb/tb_mips_multicycle_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALTED,
    ST_TRAP
  } state_t;

  // Instruction kind remembered from DECODE so later states need not re-decode ir.
  typedef enum logic [1:0] {
    K_ADD,
    K_MUL,
    K_LW,
    K_SW
  } kind_t;

  localparam logic [5:0]  OP_RTYPE          = 6'b000000;
  localparam logic [5:0]  OP_LW             = 6'b100011;
  localparam logic [5:0]  OP_SW             = 6'b101011;
  localparam logic [5:0]  FUNCT_ADD         = 6'b100000;
  localparam logic [5:0]  FUNCT_MUL         = 6'b110000;
  localparam logic [31:0] DEFAULT_HALT_WORD = 32'hFFFF_FFFF;

  localparam logic [1:0]  ALU_ADD  = 2'b00;
  localparam logic [1:0]  ALU_MUL  = 2'b01;
  localparam logic [1:0]  ALU_NONE = 2'b10;

endpackage

// File: rtl/mips_instr_class.sv
// Combinational one-hot classification of an instruction word.
module mips_instr_class
  import mips_ctrl_pkg::*;
#(
  parameter logic [31:0] HALT_WORD = DEFAULT_HALT_WORD
) (
  input  logic [31:0] instr,
  output logic        is_add,
  output logic        is_mul,
  output logic        is_lw,
  output logic        is_sw,
  output logic        is_halt,
  output logic        is_illegal
);

  logic [5:0] op;
  logic [5:0] funct;

  assign op    = instr[31:26];
  assign funct = instr[5:0];

  // Halt is checked first so the sentinel never aliases a real opcode.
  always_comb begin
    is_add     = 1'b0;
    is_mul     = 1'b0;
    is_lw      = 1'b0;
    is_sw      = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    if (instr == HALT_WORD)                             is_halt    = 1'b1;
    else if (op == OP_RTYPE && funct == FUNCT_ADD)      is_add     = 1'b1;
    else if (op == OP_RTYPE && funct == FUNCT_MUL)      is_mul     = 1'b1;
    else if (op == OP_LW)                               is_lw      = 1'b1;
    else if (op == OP_SW)                               is_sw      = 1'b1;
    else                                                is_illegal = 1'b1;
  end

endmodule

// File: rtl/mips_multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with pc, ir, mul and retire counters.
module mips_multicycle_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 151,
  parameter int unsigned MUL_CYCLES = 4,
  parameter logic [31:0] HALT_WORD  = DEFAULT_HALT_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] instr,
  input  logic        dmem_ready,
  output logic [31:0] pc,
  output logic [31:0] ir,
  output logic [1:0]  alu_sel,
  output logic        mul_busy,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        busy,
  output logic        halted,
  output logic        trap,
  output logic [31:0] instr_count
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_DEPTH);
  localparam logic [3:0]  MUL_LOAD   = 4'(MUL_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  kind_t      kind;
  logic [3:0] mul_cnt;
  logic       retire;

  logic c_add, c_mul, c_lw, c_sw, c_halt, c_illegal;

  mips_instr_class #(
    .HALT_WORD (HALT_WORD)
  ) u_class (
    .instr      (instr),
    .is_add     (c_add),
    .is_mul     (c_mul),
    .is_lw      (c_lw),
    .is_sw      (c_sw),
    .is_halt    (c_halt),
    .is_illegal (c_illegal)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state and per-state strobes; strobes come straight from state so reset clears them at once.
  always_comb begin
    state_next = state;
    // IDLE presents all-zero outputs; other non-EXEC states show "no ALU op".
    alu_sel    = (state == ST_IDLE) ? ALU_ADD : ALU_NONE;
    mul_busy   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    case (state)
      ST_IDLE, ST_HALTED: if (start) state_next = ST_FETCH;
      ST_FETCH:  state_next = (pc >= IMEM_LIMIT) ? ST_TRAP : ST_DECODE;
      ST_DECODE: begin
        if (c_halt)         state_next = ST_HALTED;
        else if (c_illegal) state_next = ST_TRAP;
        else                state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (kind == K_MUL) begin
          alu_sel  = ALU_MUL;
          mul_busy = 1'b1;
          if (mul_cnt == '0) state_next = ST_WB;
        end else begin
          alu_sel    = ALU_ADD;
          state_next = (kind == K_ADD) ? ST_WB : ST_MEM;
        end
      end
      ST_MEM: begin
        mem_read  = (kind == K_LW);
        mem_write = (kind == K_SW);
        if (dmem_ready) state_next = (kind == K_LW) ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        reg_write  = 1'b1;
        state_next = ST_FETCH;
      end
      ST_TRAP:   state_next = ST_TRAP;
      default:   state_next = ST_IDLE;
    endcase
  end

  assign retire = (state == ST_WB) || (state == ST_MEM && kind == K_SW && dmem_ready);
  assign busy   = !(state == ST_IDLE || state == ST_HALTED || state == ST_TRAP);
  assign halted = (state == ST_HALTED);
  assign trap   = (state == ST_TRAP);

  // pc, ir, instruction kind, mul down-counter and saturating retire counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= '0;
      ir          <= '0;
      kind        <= K_ADD;
      mul_cnt     <= '0;
      instr_count <= '0;
    end else begin
      if ((state == ST_IDLE || state == ST_HALTED) && start) pc <= '0;
      if (state == ST_DECODE) begin
        ir      <= instr;
        mul_cnt <= MUL_LOAD;
        if (c_add)      kind <= K_ADD;
        else if (c_mul) kind <= K_MUL;
        else if (c_lw)  kind <= K_LW;
        else            kind <= K_SW;
      end
      if (state == ST_EXEC && kind == K_MUL && mul_cnt != '0) mul_cnt <= mul_cnt - 4'd1;
      if (retire) begin
        pc <= pc + 32'd1;
        if (instr_count != '1) instr_count <= instr_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// Self-checking bench: synchronous imem model, dmem responder, retire scoreboard.
module tb_mips_multicycle_sequencer;

  localparam logic [31:0] HALT    = 32'hFFFF_FFFF;
  localparam logic [31:0] W_ADD   = 32'h0109_5820; // add $11,$8,$9
  localparam logic [31:0] W_MUL   = 32'h0109_5830; // mul $11,$8,$9
  localparam logic [31:0] W_LW    = 32'h8D0A_0004; // lw  $10,4($8)
  localparam logic [31:0] W_SW    = 32'hAD0A_0008; // sw  $10,8($8)
  localparam logic [31:0] W_JUMP  = 32'h0800_0000; // opcode 000010

  logic        clk = 1'b0;
  logic        rst_n, start, dmem_ready;
  logic [31:0] instr;
  logic [31:0] pc, ir, instr_count;
  logic [1:0]  alu_sel;
  logic        mul_busy, mem_read, mem_write, reg_write, busy, halted, trap;

  mips_multicycle_sequencer #(
    .IMEM_DEPTH (151),
    .MUL_CYCLES (4),
    .HALT_WORD  (32'hFFFF_FFFF)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .instr (instr), .dmem_ready (dmem_ready),
    .pc (pc), .ir (ir), .alu_sel (alu_sel), .mul_busy (mul_busy), .mem_read (mem_read),
    .mem_write (mem_write), .reg_write (reg_write), .busy (busy), .halted (halted),
    .trap (trap), .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  logic [31:0] imem [256];
  logic [31:0] prog [256];
  int          prog_len;

  always @(posedge clk) instr <= (pc < 32'd256) ? imem[pc[7:0]] : 32'h0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } ret_t;
  ret_t exp_q[$];
  ret_t mon_e;

  int checks = 0, failures = 0;
  int cyc = 0, start_cyc, rw_cyc, halt_cyc, last_rd_cyc;
  int rd_cycles, wr_cycles, mul_cycles, mulsel_cycles, rw_count, sw_count;
  int mem_cyc = 0, dmem_delay = 0;
  bit dmem_noise = 1'b0;
  logic halted_q = 1'b0;

  function automatic bit legal(input logic [31:0] w);
    logic [5:0] op, fn;
    op = w[31:26];
    fn = w[5:0];
    return (op == 6'h00 && (fn == 6'h20 || fn == 6'h30)) || op == 6'h23 || op == 6'h2B;
  endfunction

  // Cycle monitor: dmem responder, strobe statistics and retire scoreboard.
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      cyc++;
      if (mem_read || mem_write) begin
        mem_cyc++;
        dmem_ready = (mem_cyc > dmem_delay);
      end else begin
        mem_cyc    = 0;
        dmem_ready = dmem_noise;
      end
      if (mem_read) begin rd_cycles++; last_rd_cyc = cyc; end
      if (mem_write) wr_cycles++;
      if (mul_busy) mul_cycles++;
      if (alu_sel == 2'b01) mulsel_cycles++;
      if (mem_read || mem_write || reg_write) begin
        checks++;
        if (({1'b0, mem_read} + {1'b0, mem_write} + {1'b0, reg_write}) > 2'd1) begin
          failures++;
          $display("FAIL strobe_onehot got=%b%b%b want=at most one", mem_read, mem_write, reg_write);
        end
      end
      if (reg_write || (mem_write && dmem_ready)) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL retire_unexpected pc=%0d ir=%h want=no retire", pc, ir);
        end else begin
          mon_e = exp_q.pop_front();
          if (pc !== mon_e.pc || ir !== mon_e.word) begin
            failures++;
            $display("FAIL retire got pc=%0d ir=%h want pc=%0d ir=%h", pc, ir, mon_e.pc, mon_e.word);
          end
        end
        if (reg_write) begin
          if (rw_cyc < 0) rw_cyc = cyc;
          rw_count++;
        end else sw_count++;
      end
      if (halted && !halted_q && halt_cyc < 0) halt_cyc = cyc;
      halted_q = halted;
    end
  end

  task automatic clear_stats();
    rw_cyc = -1; halt_cyc = -1; last_rd_cyc = -1;
    rd_cycles = 0; wr_cycles = 0; mul_cycles = 0; mulsel_cycles = 0;
    rw_count = 0; sw_count = 0;
  endtask

  task automatic do_reset();
    start = 1'b0; dmem_delay = 0; dmem_noise = 1'b0; dmem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
    clear_stats();
  endtask

  task automatic push_expect();
    ret_t r;
    for (int i = 0; i < prog_len; i++) begin
      if (prog[i] == HALT || !legal(prog[i])) break;
      r.pc   = 32'(i);
      r.word = prog[i];
      exp_q.push_back(r);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) imem[i] = (i < prog_len) ? prog[i] : 32'h0;
    push_expect();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (halted || trap) begin timed_out = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    start = 1'b0; dmem_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({mem_read, mem_write, reg_write, mul_busy, busy, halted, trap} !== 7'b0) begin
      failures++; $display("FAIL reset_flags got=%b want=0", {mem_read, mem_write, reg_write, mul_busy, busy, halted, trap});
    end
    checks++;
    if (pc !== 32'd0 || ir !== 32'd0) begin failures++; $display("FAIL reset_pc_ir got pc=%h ir=%h want=0", pc, ir); end
    checks++;
    if (instr_count !== 32'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", instr_count); end
    checks++;
    if (alu_sel !== 2'b00) begin failures++; $display("FAIL reset_alu_sel got=%b want=00", alu_sel); end
    rst_n = 1'b1;
    @(negedge clk);
    clear_stats();
  endtask

  task automatic test_add_halt();
    bit to;
    do_reset();
    prog_len = 2; prog[0] = W_ADD; prog[1] = HALT;
    load_prog();
    pulse_start();
    wait_end(100, to);
    checks++; if (to) begin failures++; $display("FAIL add_timeout got=timeout want=halted"); end
    checks++; if (rw_cyc - start_cyc != 4) begin failures++; $display("FAIL add_wb_cycle got=%0d want=4", rw_cyc - start_cyc); end
    checks++; if (halt_cyc - start_cyc != 7) begin failures++; $display("FAIL add_halt_cycle got=%0d want=7", halt_cyc - start_cyc); end
    checks++; if (pc !== 32'd1) begin failures++; $display("FAIL add_pc got=%0d want=1", pc); end
    checks++; if (instr_count !== 32'd1 || rw_count != 1) begin failures++; $display("FAIL add_count got=%0d/%0d want=1/1", instr_count, rw_count); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL add_sb_left got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_lw_wait();
    bit to;
    do_reset();
    prog_len = 2; prog[0] = W_LW; prog[1] = HALT;
    load_prog();
    dmem_delay = 3;
    pulse_start();
    wait_end(100, to);
    checks++; if (to) begin failures++; $display("FAIL lw_timeout got=timeout want=halted"); end
    checks++; if (rd_cycles != 4) begin failures++; $display("FAIL lw_read_cycles got=%0d want=4", rd_cycles); end
    checks++; if (rw_cyc != last_rd_cyc + 1) begin failures++; $display("FAIL lw_wb_follow got=%0d want=%0d", rw_cyc, last_rd_cyc + 1); end
    checks++; if (pc !== 32'd1) begin failures++; $display("FAIL lw_pc got=%0d want=1", pc); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL lw_sb_left got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_mul();
    bit to;
    do_reset();
    prog_len = 2; prog[0] = W_MUL; prog[1] = HALT;
    load_prog();
    dmem_noise = 1'b1;
    pulse_start();
    wait_end(100, to);
    checks++; if (to) begin failures++; $display("FAIL mul_timeout got=timeout want=halted"); end
    checks++; if (mul_cycles != 4 || mulsel_cycles != 4) begin failures++; $display("FAIL mul_busy_cycles got=%0d/%0d want=4/4", mul_cycles, mulsel_cycles); end
    checks++; if (rw_cyc - start_cyc != 7) begin failures++; $display("FAIL mul_wb_cycle got=%0d want=7", rw_cyc - start_cyc); end
    checks++; if (rd_cycles + wr_cycles != 0) begin failures++; $display("FAIL mul_mem_strobes got=%0d want=0", rd_cycles + wr_cycles); end
    checks++; if (instr_count !== 32'd1) begin failures++; $display("FAIL mul_count got=%0d want=1", instr_count); end
  endtask

  task automatic test_trap();
    bit to;
    do_reset();
    prog_len = 3; prog[0] = W_ADD; prog[1] = W_ADD; prog[2] = W_JUMP;
    load_prog();
    pulse_start();
    wait_end(100, to);
    checks++; if (to) begin failures++; $display("FAIL trap_timeout got=timeout want=trap"); end
    checks++; if (trap !== 1'b1 || busy !== 1'b0 || pc !== 32'd2) begin failures++; $display("FAIL trap_state got trap=%b busy=%b pc=%0d want 1/0/2", trap, busy, pc); end
    checks++; if (ir !== W_JUMP || instr_count !== 32'd2) begin failures++; $display("FAIL trap_ir got ir=%h cnt=%0d want %h/2", ir, instr_count, W_JUMP); end
    pulse_start();
    repeat (3) @(negedge clk);
    checks++; if (trap !== 1'b1 || busy !== 1'b0 || halted !== 1'b0 || pc !== 32'd2) begin failures++; $display("FAIL trap_sticky got trap=%b busy=%b pc=%0d want 1/0/2", trap, busy, pc); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL trap_sb_left got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_pc_limit();
    bit to;
    do_reset();
    prog_len = 151;
    for (int i = 0; i < 151; i++) prog[i] = W_ADD;
    load_prog();
    pulse_start();
    wait_end(1000, to);
    checks++; if (to || trap !== 1'b1) begin failures++; $display("FAIL limit_trap got trap=%b to=%0d want trap=1", trap, to); end
    checks++; if (pc !== 32'd151 || instr_count !== 32'd151) begin failures++; $display("FAIL limit_pc got pc=%0d cnt=%0d want 151/151", pc, instr_count); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL limit_sb_left got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_sw();
    bit seen;
    do_reset();
    prog_len = 3; prog[0] = W_ADD; prog[1] = W_SW; prog[2] = HALT;
    load_prog();
    dmem_delay = 5;
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_write) begin seen = 1'b1; break; end
    end
    checks++; if (!seen) begin failures++; $display("FAIL rst_sw_reach got=no mem_write want=mem_write"); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (mem_write !== 1'b0) begin failures++; $display("FAIL rst_sw_strobe got=%b want=0", mem_write); end
    checks++; if (pc !== 32'd0 || instr_count !== 32'd0) begin failures++; $display("FAIL rst_sw_regs got pc=%0d cnt=%0d want 0/0", pc, instr_count); end
    checks++; if (busy !== 1'b0 || halted !== 1'b0 || trap !== 1'b0) begin failures++; $display("FAIL rst_sw_idle got busy=%b halted=%b trap=%b want 000", busy, halted, trap); end
    rst_n = 1'b1;
    @(negedge clk);
    exp_q.delete();
    clear_stats();
  endtask

  task automatic test_back_to_back();
    bit to;
    do_reset();
    prog_len = 6;
    prog[0] = W_ADD; prog[1] = W_SW; prog[2] = W_LW; prog[3] = W_MUL; prog[4] = W_SW; prog[5] = HALT;
    load_prog();
    pulse_start();
    wait_end(200, to);
    checks++; if (to) begin failures++; $display("FAIL b2b_timeout got=timeout want=halted"); end
    checks++; if (halt_cyc - start_cyc != 27) begin failures++; $display("FAIL b2b_latency got=%0d want=27", halt_cyc - start_cyc); end
    checks++; if (wr_cycles != 2 || rd_cycles != 1) begin failures++; $display("FAIL b2b_mem_cycles got=%0d/%0d want=2/1", wr_cycles, rd_cycles); end
    checks++; if (pc !== 32'd5 || instr_count !== 32'd5) begin failures++; $display("FAIL b2b_pc got pc=%0d cnt=%0d want 5/5", pc, instr_count); end
    // Restart from HALTED runs the program again from word 0.
    push_expect();
    clear_stats();
    pulse_start();
    wait_end(200, to);
    checks++; if (to || halted !== 1'b1 || pc !== 32'd5) begin failures++; $display("FAIL b2b_rerun got halted=%b pc=%0d want 1/5", halted, pc); end
    checks++; if (exp_q.size() != 0 || sw_count != 2) begin failures++; $display("FAIL b2b_sb got left=%0d sw=%0d want 0/2", exp_q.size(), sw_count); end
  endtask

  task automatic test_matrix();
    bit to;
    int k;
    do_reset();
    k = 0;
    for (int e = 0; e < 9; e++) begin
      for (int j = 0; j < 6; j++) begin prog[k] = W_LW | 32'(j * 4); k++; end
      for (int j = 0; j < 3; j++) begin prog[k] = W_MUL; k++; end
      for (int j = 0; j < 2; j++) begin prog[k] = W_ADD; k++; end
      prog[k] = W_SW | 32'(e * 4); k++;
    end
    prog[108] = HALT;
    prog_len = 109;
    load_prog();
    dmem_delay = 1;
    pulse_start();
    repeat (40) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_end(3000, to);
    checks++; if (to || halted !== 1'b1) begin failures++; $display("FAIL mtx_halt got halted=%b to=%0d want 1", halted, to); end
    checks++; if (pc !== 32'd108 || instr_count !== 32'd108) begin failures++; $display("FAIL mtx_pc got pc=%0d cnt=%0d want 108/108", pc, instr_count); end
    checks++; if (sw_count != 9 || rw_count != 99) begin failures++; $display("FAIL mtx_retires got sw=%0d wb=%0d want 9/99", sw_count, rw_count); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL mtx_sb_left got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    dmem_ready = 1'b0;
    clear_stats();
    test_reset();
    test_add_halt();
    test_lw_wait();
    test_mul();
    test_trap();
    test_pc_limit();
    test_reset_mid_sw();
    test_back_to_back();
    test_matrix();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
